tlb_ctrl: RTL and testbench

TLB_CTRL -- requirements
Module: tlb_ctrl

---
 rtl/tlb_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_tlb_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tlb_ctrl
// Purpose  : Direct-mapped TLB controller in front of a dual-port SRAM
//            (port 0 write-only, port 1 lookup-only). Handles lookups with
//            a fixed two-cycle response, single-cycle entry fills, and an
//            invalidate-all flush that also runs after every reset release.
// Options  : TLB_STATS_EN - when defined, adds saturating hit/miss counters;
//            otherwise stat_hits/stat_misses are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module tlb_ctrl #(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    // lookup request
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_va,
    // lookup response (no backpressure)
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [31:0]      resp_pa,
    output logic [3:0]       resp_perm,
    // entry install
    input  logic             fill_valid,
    output logic             fill_ready,
    input  logic [31:0]      fill_va,
    input  logic [31:0]      fill_pa,
    input  logic [3:0]       fill_perm,
    // invalidate-all
    input  logic             flush_req,
    output logic             flush_busy,
    // SRAM port 0 (write) and port 1 (read)
    output logic             sram_csb0,
    output logic             sram_web0,
    output logic [IDX_W-1:0] sram_addr0,
    output logic [63:0]      sram_din0,
    output logic             sram_csb1,
    output logic [IDX_W-1:0] sram_addr1,
    input  logic [63:0]      sram_dout1,
    // statistics
    output logic [31:0]      stat_hits,
    output logic [31:0]      stat_misses
);

    localparam int               TAG_W    = 14;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t             state_q;
    logic               flush_pend_q;   // flush owed after reset release
    logic [IDX_W-1:0]   flush_idx_q;

    // lookup pipeline: stage 1 = SRAM address captured, stage 2 = data out
    logic               s1_valid_q, s2_valid_q;
    logic [TAG_W-1:0]   s1_tag_q,   s2_tag_q;
    logic [11:0]        s1_off_q,   s2_off_q;

    logic               fill_acc;
    logic               req_acc;
    logic               entry_hit;

    // Handshakes: fills win over lookups; nothing is accepted while flushing
    // or while the post-reset flush is still pending.
    assign fill_ready = (state_q == ST_IDLE) && !flush_pend_q;
    assign fill_acc   = fill_valid && fill_ready;
    assign req_ready  = fill_ready && !fill_valid;
    assign req_acc    = req_valid && req_ready;
    assign flush_busy = (state_q == ST_FLUSH);

    // Write port: flush zeroes one entry per cycle, otherwise an accepted fill
    always_comb begin
        sram_csb0  = 1'b1;
        sram_web0  = 1'b1;
        sram_addr0 = '0;
        sram_din0  = '0;
        if (state_q == ST_FLUSH) begin
            sram_csb0  = 1'b0;
            sram_web0  = 1'b0;
            sram_addr0 = flush_idx_q;
        end else if (fill_acc) begin
            sram_csb0  = 1'b0;
            sram_web0  = 1'b0;
            sram_addr0 = fill_va[12 +: IDX_W];
            sram_din0  = {1'b1, fill_va[31 -: TAG_W], fill_pa[31:12],
                          fill_perm, 25'd0};
        end
    end

    // Read port is driven in the same cycle the lookup is accepted
    assign sram_csb1  = !req_acc;
    assign sram_addr1 = req_va[12 +: IDX_W];

    // Control FSM: IDLE <-> FLUSH, with flush_idx_q sweeping every entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            flush_pend_q <= 1'b1;
            flush_idx_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (flush_pend_q || flush_req) begin
                        state_q      <= ST_FLUSH;
                        flush_pend_q <= 1'b0;
                        flush_idx_q  <= '0;
                    end
                end
                ST_FLUSH: begin
                    flush_idx_q <= flush_idx_q + 1'b1;
                    if (flush_idx_q == LAST_IDX) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Carry tag and page offset alongside the SRAM's two-cycle read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_tag_q   <= '0;
            s2_tag_q   <= '0;
            s1_off_q   <= '0;
            s2_off_q   <= '0;
        end else begin
            s1_valid_q <= req_acc;
            s2_valid_q <= s1_valid_q;
            s1_tag_q   <= req_va[31 -: TAG_W];
            s2_tag_q   <= s1_tag_q;
            s1_off_q   <= req_va[11:0];
            s2_off_q   <= s1_off_q;
        end
    end

    // Compare the returned entry against the tag that travelled with it
    assign entry_hit  = sram_dout1[63] && (sram_dout1[62:49] == s2_tag_q);
    assign resp_valid = s2_valid_q;
    assign resp_hit   = s2_valid_q && entry_hit;
    assign resp_pa    = resp_hit ? {sram_dout1[48:29], s2_off_q} : 32'd0;
    assign resp_perm  = resp_hit ? sram_dout1[28:25] : 4'd0;

`ifdef TLB_STATS_EN
    logic [31:0] hits_q, hits_d;
    logic [31:0] misses_q, misses_d;

    // Saturating counters; only reset clears them, flush leaves them alone
    always_comb begin
        hits_d   = hits_q;
        misses_d = misses_q;
        if (resp_valid) begin
            if (resp_hit) begin
                if (hits_q != 32'hFFFF_FFFF) hits_d = hits_q + 32'd1;
            end else begin
                if (misses_q != 32'hFFFF_FFFF) misses_d = misses_q + 32'd1;
            end
        end
    end

    // Counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`else
    assign stat_hits   = 32'd0;
    assign stat_misses = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tlb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlb_ctrl
// Purpose  : Self-checking bench for tlb_ctrl. A behavioural SRAM and a
//            table-level TLB model predict every output each cycle; a few
//            directed scenarios pin literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlb_ctrl;

`ifdef TLB_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [31:0] req_va = '0;
    logic        resp_valid, resp_hit;
    logic [31:0] resp_pa;
    logic [3:0]  resp_perm;
    logic        fill_valid = 1'b0, fill_ready;
    logic [31:0] fill_va = '0, fill_pa = '0;
    logic [3:0]  fill_perm = '0;
    logic        flush_req = 1'b0, flush_busy;
    logic        sram_csb0, sram_web0, sram_csb1;
    logic [5:0]  sram_addr0, sram_addr1;
    logic [63:0] sram_din0;
    logic [63:0] sram_dout1 = '0;
    logic [31:0] stat_hits, stat_misses;

    tlb_ctrl #(.ENTRIES(64), .IDX_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_pa(resp_pa),
        .resp_perm(resp_perm),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_va(fill_va),
        .fill_pa(fill_pa), .fill_perm(fill_perm),
        .flush_req(flush_req), .flush_busy(flush_busy),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
        .sram_din0(sram_din0), .sram_csb1(sram_csb1), .sram_addr1(sram_addr1),
        .sram_dout1(sram_dout1),
        .stat_hits(stat_hits), .stat_misses(stat_misses)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural SRAM (2-edge read latency) ----------------
    logic [63:0] mem [64];
    logic [63:0] rd_q;
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
    end
    always @(posedge clk) begin
        if (!sram_csb0 && !sram_web0) mem[sram_addr0] <= sram_din0;
        if (!sram_csb1) rd_q <= mem[sram_addr1];
        sram_dout1 <= rd_q;
    end

    // ---------------- bookkeeping ----------------
    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    endtask

    // ---------------- table-level reference model ----------------
    typedef struct {
        int          due;
        bit          hit;
        logic [31:0] pa;
        logic [3:0]  perm;
    } resp_t;

    resp_t       rq[$];
    bit          m_v    [64];
    logic [13:0] m_tag  [64];
    logic [19:0] m_ppn  [64];
    logic [3:0]  m_perm [64];
    bit          m_pend = 1'b1;
    int          m_cnt = 0;     // flush cycles remaining
    logic [31:0] m_hits = '0, m_miss = '0;

    // captured from the DUT for the literal checks
    logic        last_hit = 1'b0;
    logic [31:0] last_pa = '0;
    logic [3:0]  last_perm = '0;

    always @(negedge clk) begin
        bit          busy, frdy, facc, rrdy, racc, expv;
        resp_t       r;
        int          idx;
        logic [13:0] tg;
        if (!rst_n) begin
            m_pend = 1'b1; m_cnt = 0; rq.delete(); m_hits = '0; m_miss = '0;
            chk("rst_req_ready",  req_ready, 0);
            chk("rst_fill_ready", fill_ready, 0);
            chk("rst_flush_busy", flush_busy, 0);
            chk("rst_csb0",       sram_csb0, 1);
            chk("rst_web0",       sram_web0, 1);
            chk("rst_csb1",       sram_csb1, 1);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_stat_hits",  stat_hits, 0);
            chk("rst_stat_miss",  stat_misses, 0);
        end else begin
            busy = (m_cnt > 0);
            frdy = !busy && !m_pend;
            facc = fill_valid && frdy;
            rrdy = frdy && !fill_valid;
            racc = req_valid && rrdy;
            chk("flush_busy", flush_busy, busy);
            chk("fill_ready", fill_ready, frdy);
            chk("req_ready",  req_ready, rrdy);
            if (busy) begin
                chk("flush_csb0",  sram_csb0, 0);
                chk("flush_web0",  sram_web0, 0);
                chk("flush_addr0", sram_addr0, 64 - m_cnt);
                chk("flush_din0",  sram_din0, 0);
            end else if (facc) begin
                chk("fill_csb0",  sram_csb0, 0);
                chk("fill_web0",  sram_web0, 0);
                chk("fill_addr0", sram_addr0, fill_va[17:12]);
                chk("fill_din0",  sram_din0,
                    {1'b1, fill_va[31:18], fill_pa[31:12], fill_perm, 25'd0});
            end else begin
                chk("quiet_csb0", sram_csb0, 1);
                chk("quiet_web0", sram_web0, 1);
            end
            chk("csb1", sram_csb1, !racc);
            if (racc) chk("addr1", sram_addr1, req_va[17:12]);

            expv = (rq.size() > 0) && (rq[0].due == cyc);
            if (expv) r = rq.pop_front();
            else begin r.hit = 0; r.pa = '0; r.perm = '0; end
            chk("resp_valid", resp_valid, expv);
            chk("resp_hit",   resp_hit,   r.hit);
            chk("resp_pa",    resp_pa,    r.pa);
            chk("resp_perm",  resp_perm,  r.perm);
            chk("stat_hits",   stat_hits,   STATS_ON ? m_hits : 32'd0);
            chk("stat_misses", stat_misses, STATS_ON ? m_miss : 32'd0);
            if (expv) begin
                last_hit = resp_hit; last_pa = resp_pa; last_perm = resp_perm;
                if (r.hit) m_hits = (m_hits == 32'hFFFF_FFFF) ? m_hits : m_hits + 1;
                else       m_miss = (m_miss == 32'hFFFF_FFFF) ? m_miss : m_miss + 1;
            end

            // what the coming clock edge does to the table
            if (racc) begin
                idx = int'(req_va[17:12]);
                tg  = req_va[31:18];
                r.due  = cyc + 2;
                r.hit  = m_v[idx] && (m_tag[idx] == tg);
                r.pa   = r.hit ? {m_ppn[idx], req_va[11:0]} : 32'd0;
                r.perm = r.hit ? m_perm[idx] : 4'd0;
                rq.push_back(r);
            end
            if (facc) begin
                idx = int'(fill_va[17:12]);
                m_v[idx] = 1'b1; m_tag[idx] = fill_va[31:18];
                m_ppn[idx] = fill_pa[31:12]; m_perm[idx] = fill_perm;
            end
            if (m_pend || (!busy && flush_req)) begin
                m_pend = 1'b0; m_cnt = 64;
                for (int i = 0; i < 64; i++) m_v[i] = 1'b0;
            end else if (busy) begin
                m_cnt--;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask
    task automatic clr();
        req_valid = 0; fill_valid = 0; flush_req = 0;
    endtask
    task automatic do_idle(input int n);
        repeat (n) begin tick(); clr(); end
    endtask
    task automatic do_look(input logic [31:0] va);
        tick(); clr(); req_valid = 1; req_va = va;
    endtask
    task automatic do_fill(input logic [31:0] va, input logic [31:0] pa, input logic [3:0] p);
        tick(); clr(); fill_valid = 1; fill_va = va; fill_pa = pa; fill_perm = p;
    endtask
    task automatic wait_idle();
        bit ok = 0;
        tick(); clr();
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (fill_ready === 1'b1) ok = 1;
        end
        if (!ok) chk("wait_idle_timeout", 0, 1);
    endtask
    task automatic count_flush(input string name);
        int  n = 0;
        bit  ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (flush_busy === 1'b1) n++;
            if (req_ready === 1'b1 && fill_ready === 1'b1) ok = 1;
        end
        chk(name, n, 64);
    endtask

    logic [13:0] tagset [4];

    initial begin
        tagset[0] = 14'h0010; tagset[1] = 14'h0011;
        tagset[2] = 14'h002A; tagset[3] = 14'h3FFF;

        // reset held, then released: 64-entry flush before anything is ready
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        count_flush("flush_len_after_reset");

        // fill then hit
        do_fill(32'h0001_2000, 32'h8005_5000, 4'hF);
        do_look(32'h0001_2ABC);
        do_idle(3);
        chk("hit028_hit",  last_hit, 1);
        chk("hit028_pa",   last_pa, 32'h8005_5ABC);
        chk("hit028_perm", last_perm, 4'hF);

        // same index, different tag -> miss
        do_look(32'h0041_2000);
        do_idle(3);
        chk("miss029_hit",  last_hit, 0);
        chk("miss029_pa",   last_pa, 0);
        chk("miss029_perm", last_perm, 0);
        chk("stats_hits_lit",   stat_hits,   STATS_ON ? 32'd1 : 32'd0);
        chk("stats_misses_lit", stat_misses, STATS_ON ? 32'd1 : 32'd0);

        // four back-to-back lookups, mixed hit/miss
        do_fill(32'h0003_4000, 32'h1234_5000, 4'h5);
        do_look(32'h0001_2004);
        do_look(32'h0003_4FFF);
        do_look(32'h0041_2000);
        do_look(32'h0003_5000);
        do_idle(3);
        chk("b2b_last_hit", last_hit, 0);

        // flush with two lookups in flight; flush_req and fills during flush ignored
        do_look(32'h0001_2ABC);
        tick(); clr(); req_valid = 1; req_va = 32'h0003_4000; flush_req = 1;
        repeat (20) begin
            tick(); clr(); flush_req = 1;
            fill_valid = 1; fill_va = 32'h0007_7000; fill_pa = 32'hDEAD_B000; fill_perm = 4'h3;
        end
        wait_idle();
        chk("inflight_old_hit", last_hit, 1);
        chk("inflight_old_pa",  last_pa, 32'h1234_5000);
        do_look(32'h0001_2ABC);
        do_idle(3);
        chk("after_flush_hit", last_hit, 0);
        chk("after_flush_pa",  last_pa, 0);

        // fill coinciding with flush_req: written, then wiped
        do_fill(32'h0005_6000, 32'hAAAA_A000, 4'h9);
        flush_req = 1;
        wait_idle();
        do_look(32'h0005_6123);
        do_idle(3);
        chk("fill_flush_hit", last_hit, 0);

        // reset in the middle of a flush restarts it from index 0
        tick(); clr(); flush_req = 1;
        do_idle(12);
        rst_n = 1'b0;
        do_idle(2);
        rst_n = 1'b1;
        count_flush("flush_len_after_midflush_reset");

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tick(); clr();
            req_valid  = $urandom_range(0, 1);
            req_va     = {tagset[$urandom_range(0, 3)], 6'($urandom_range(0, 7)), 12'($urandom)};
            fill_valid = ($urandom_range(0, 3) == 0);
            fill_va    = {tagset[$urandom_range(0, 3)], 6'($urandom_range(0, 7)), 12'($urandom)};
            fill_pa    = $urandom;
            fill_perm  = 4'($urandom);
            flush_req  = ($urandom_range(0, 299) == 0);
        end
        do_idle(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
